trace_buf: RTL and testbench

Parametrised instruction-trace capture buffer sitting beside the CPU core. It snoops retired (pc, inst) pairs into a circular buffer and freezes a configurable number of entries after a trigger. It is read back by age index, replacing per-instruction console dumps with a synthesizable, pre/post-trigger history window. It attaches to the CPU retire signals and is read by a debug host or a bench.

---
 rtl/trace_buf_if.sv | 32 +++
 rtl/trace_buf.sv | 144 ++++++++++++++
 tb/tb_trace_buf.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_buf_if.sv
// Bus bundle for trace_buf: retire snoop inputs, arm/trigger control and the age-indexed read port.
// Read handshake: trc_rd_req sampled on an edge is always accepted (no back-pressure) and yields trc_rd_valid with data for exactly the next cycle.
interface trace_buf_if #(
    parameter int PC_W       = 32,
    parameter int INST_W     = 32,
    parameter int DEPTH_LOG2 = 4
);
    logic                  trc_arm;
    logic                  trc_valid;
    logic [PC_W-1:0]       trc_pc;
    logic [INST_W-1:0]     trc_inst;
    logic                  trc_trig;
    logic                  trc_rd_req;
    logic [DEPTH_LOG2-1:0] trc_rd_idx;
    logic                  trc_rd_valid;
    logic [PC_W-1:0]       trc_rd_pc;
    logic [INST_W-1:0]     trc_rd_inst;
    logic [31:0]           trc_rd_ts;
    logic [DEPTH_LOG2:0]   trc_count;
    logic [1:0]            trc_state;
    logic                  trc_done;

    modport master (
        output trc_arm, trc_valid, trc_pc, trc_inst, trc_trig, trc_rd_req, trc_rd_idx,
        input  trc_rd_valid, trc_rd_pc, trc_rd_inst, trc_rd_ts, trc_count, trc_state, trc_done
    );

    modport slave (
        input  trc_arm, trc_valid, trc_pc, trc_inst, trc_trig, trc_rd_req, trc_rd_idx,
        output trc_rd_valid, trc_rd_pc, trc_rd_inst, trc_rd_ts, trc_count, trc_state, trc_done
    );
endinterface

// File: rtl/trace_buf.sv
// Instruction-trace capture buffer with pre/post-trigger window, read back by age index.
// Optional per-entry cycle timestamps are built when TRC_TIMESTAMP_EN is defined.
module trace_buf #(
    parameter int PC_W       = 32,
    parameter int INST_W     = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int POST_TRIG  = 8
) (
    input  logic        trc_clk,
    input  logic        trc_rst,
    trace_buf_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL      = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   POST_INIT = (DEPTH_LOG2+1)'(POST_TRIG);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   post_cnt;
    logic                  done;
    logic                  capture;

    logic [PC_W-1:0]       mem_pc   [DEPTH];
    logic [INST_W-1:0]     mem_inst [DEPTH];

    logic [DEPTH_LOG2-1:0] rd_slot;
    logic                  rd_hit;
    logic                  rd_valid;
    logic [PC_W-1:0]       rd_pc;
    logic [INST_W-1:0]     rd_inst;

    // Arm takes priority over a same-cycle retire, so that entry is dropped.
    assign capture = !bus.trc_arm && bus.trc_valid && (state == S_ARMED || state == S_POST);

    always_ff @(posedge trc_clk or posedge trc_rst) begin
        if (trc_rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            done     <= 1'b0;
        end else if (bus.trc_arm) begin
            state    <= S_ARMED;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= POST_INIT;
            done     <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (count != FULL) count <= count + CNT_ONE;
            end
            case (state)
                S_ARMED: begin
                    // The trigger entry itself does not consume the post budget.
                    if (bus.trc_trig) begin
                        if (POST_TRIG == 0) begin
                            state <= S_FROZEN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (capture) begin
                        post_cnt <= post_cnt - CNT_ONE;
                        if (post_cnt == CNT_ONE) begin
                            state <= S_FROZEN;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge trc_clk) begin
        if (capture) begin
            mem_pc[wr_ptr]   <= bus.trc_pc;
            mem_inst[wr_ptr] <= bus.trc_inst;
        end
    end

    // Oldest held entry sits count slots behind the write pointer.
    assign rd_slot = wr_ptr - count[DEPTH_LOG2-1:0] + bus.trc_rd_idx;
    assign rd_hit  = {1'b0, bus.trc_rd_idx} < count;

    always_ff @(posedge trc_clk or posedge trc_rst) begin
        if (trc_rst) begin
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_inst  <= '0;
        end else begin
            rd_valid <= bus.trc_rd_req;
            if (bus.trc_rd_req) begin
                rd_pc   <= rd_hit ? mem_pc[rd_slot]   : '0;
                rd_inst <= rd_hit ? mem_inst[rd_slot] : '0;
            end
        end
    end

`ifdef TRC_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] mem_ts [DEPTH];
    logic [31:0] rd_ts;

    always_ff @(posedge trc_clk or posedge trc_rst) begin
        if (trc_rst) begin
            ts_cnt <= '0;
            rd_ts  <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (bus.trc_rd_req) rd_ts <= rd_hit ? mem_ts[rd_slot] : '0;
        end
    end

    always_ff @(posedge trc_clk) begin
        if (capture) mem_ts[wr_ptr] <= ts_cnt;
    end

    assign bus.trc_rd_ts = rd_ts;
`else
    assign bus.trc_rd_ts = '0;
`endif

    assign bus.trc_rd_valid = rd_valid;
    assign bus.trc_rd_pc    = rd_pc;
    assign bus.trc_rd_inst  = rd_inst;
    assign bus.trc_count    = count;
    assign bus.trc_state    = state;
    assign bus.trc_done     = done;
endmodule

// File: tb/tb_trace_buf.sv
// Randomized and directed bench for trace_buf: two instances (POST_TRIG 2 and 0) share stimulus
// and are checked against a history-list reference model.
module tb_trace_buf;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int PT_A  = 2;
    localparam int PT_B  = 0;
    localparam int HMAX  = 1024;

    logic trc_clk = 1'b0;
    logic trc_rst = 1'b1;
    always #5 trc_clk = ~trc_clk;

    trace_buf_if #(.PC_W(32), .INST_W(32), .DEPTH_LOG2(DL)) if_a ();
    trace_buf_if #(.PC_W(32), .INST_W(32), .DEPTH_LOG2(DL)) if_b ();

    trace_buf #(.PC_W(32), .INST_W(32), .DEPTH_LOG2(DL), .POST_TRIG(PT_A)) u_dut_a (
        .trc_clk(trc_clk), .trc_rst(trc_rst), .bus(if_a.slave)
    );
    trace_buf #(.PC_W(32), .INST_W(32), .DEPTH_LOG2(DL), .POST_TRIG(PT_B)) u_dut_b (
        .trc_clk(trc_clk), .trc_rst(trc_rst), .bus(if_b.slave)
    );

    int total = 0;
    int bad   = 0;

    // stimulus currently applied
    logic        s_arm, s_valid, s_trig, s_rd_req;
    logic [31:0] s_pc, s_inst;
    logic [DL-1:0] s_rd_idx;

    // reference model: every entry captured since the last arm, newest last
    logic [95:0] hist [2][HMAX];
    int          hcnt  [2];
    int          m_st  [2];
    int          m_rem [2];
    logic        m_rv  [2];
    logic [95:0] m_rd  [2];
    int          cyc;
    logic [95:0] exp_q_a [$];
    logic [95:0] exp_q_b [$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ts_now();
`ifdef TRC_TIMESTAMP_EN
        return 32'(cyc);
`else
        return 32'd0;
`endif
    endfunction

    function automatic int held(input int d);
        return (hcnt[d] < DEPTH) ? hcnt[d] : DEPTH;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            hcnt[d] = 0; m_st[d] = 0; m_rem[d] = 0; m_rv[d] = 1'b0; m_rd[d] = '0;
        end
        exp_q_a.delete();
        exp_q_b.delete();
        cyc = 0;
    endtask

    task automatic model_step(input int d, input int pt);
        logic [95:0] e;
        int h;
        h = held(d);
        m_rv[d] = s_rd_req;
        if (s_rd_req) begin
            e = '0;
            if (int'(s_rd_idx) < h) e = hist[d][hcnt[d] - h + int'(s_rd_idx)];
            if (d == 0) exp_q_a.push_back(e); else exp_q_b.push_back(e);
        end
        if (s_arm) begin
            hcnt[d] = 0; m_st[d] = 1; m_rem[d] = pt;
        end else if (m_st[d] == 1 || m_st[d] == 2) begin
            if (s_valid && hcnt[d] < HMAX) begin
                hist[d][hcnt[d]] = {s_pc, s_inst, ts_now()};
                hcnt[d]++;
            end
            if (m_st[d] == 1) begin
                if (s_trig) m_st[d] = (pt == 0) ? 3 : 2;
            end else if (s_valid) begin
                m_rem[d]--;
                if (m_rem[d] == 0) m_st[d] = 3;
            end
        end
    endtask

    task automatic check_dut(input int d);
        string p;
        logic [1:0] st; logic [DL:0] cnt; logic dn, rv; logic [95:0] rd;
        if (d == 0) begin
            p = "a"; st = if_a.trc_state; cnt = if_a.trc_count; dn = if_a.trc_done;
            rv = if_a.trc_rd_valid; rd = {if_a.trc_rd_pc, if_a.trc_rd_inst, if_a.trc_rd_ts};
        end else begin
            p = "b"; st = if_b.trc_state; cnt = if_b.trc_count; dn = if_b.trc_done;
            rv = if_b.trc_rd_valid; rd = {if_b.trc_rd_pc, if_b.trc_rd_inst, if_b.trc_rd_ts};
        end
        check($sformatf("%s_state", p), 96'(st), 96'(m_st[d]));
        check($sformatf("%s_count", p), 96'(cnt), 96'(held(d)));
        check($sformatf("%s_done", p), 96'(dn), 96'(m_st[d] == 3));
        check($sformatf("%s_rd_valid", p), 96'(rv), 96'(m_rv[d]));
        if (m_rv[d]) begin
            if (d == 0 && exp_q_a.size() > 0) m_rd[d] = exp_q_a.pop_front();
            else if (d == 1 && exp_q_b.size() > 0) m_rd[d] = exp_q_b.pop_front();
        end
        check($sformatf("%s_rd_data", p), rd, m_rd[d]);
    endtask

    task automatic step(input logic arm, input logic valid, input logic [31:0] pc,
                        input logic [31:0] inst, input logic trig, input logic rd_req,
                        input logic [DL-1:0] idx);
        s_arm = arm; s_valid = valid; s_pc = pc; s_inst = inst;
        s_trig = trig; s_rd_req = rd_req; s_rd_idx = idx;
        if_a.trc_arm = arm; if_a.trc_valid = valid; if_a.trc_pc = pc; if_a.trc_inst = inst;
        if_a.trc_trig = trig; if_a.trc_rd_req = rd_req; if_a.trc_rd_idx = idx;
        if_b.trc_arm = arm; if_b.trc_valid = valid; if_b.trc_pc = pc; if_b.trc_inst = inst;
        if_b.trc_trig = trig; if_b.trc_rd_req = rd_req; if_b.trc_rd_idx = idx;
        @(posedge trc_clk);
        model_step(0, PT_A);
        model_step(1, PT_B);
        cyc++;
        @(negedge trc_clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic arm();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr(input logic [31:0] pc, input logic trig);
        step(1'b0, 1'b1, pc, $urandom, trig, 1'b0, '0);
    endtask

    task automatic rd(input int idx);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, DL'(idx));
    endtask

    initial begin
        int since_arm;
        logic [31:0] ts5, ts9;
        s_arm = 0; s_valid = 0; s_pc = 0; s_inst = 0; s_trig = 0; s_rd_req = 0; s_rd_idx = '0;
        if_a.trc_arm = 0; if_a.trc_valid = 0; if_a.trc_pc = 0; if_a.trc_inst = 0;
        if_a.trc_trig = 0; if_a.trc_rd_req = 0; if_a.trc_rd_idx = '0;
        if_b.trc_arm = 0; if_b.trc_valid = 0; if_b.trc_pc = 0; if_b.trc_inst = 0;
        if_b.trc_trig = 0; if_b.trc_rd_req = 0; if_b.trc_rd_idx = '0;
        model_reset();

        // reset state
        repeat (2) @(negedge trc_clk);
        check("rst_state", 96'(if_a.trc_state), 96'd0);
        check("rst_count", 96'(if_a.trc_count), 96'd0);
        check("rst_done", 96'(if_a.trc_done), 96'd0);
        check("rst_rd", {if_a.trc_rd_valid, if_a.trc_rd_pc, if_a.trc_rd_inst, if_a.trc_rd_ts}, '0);
        trc_rst = 1'b0;
        model_reset();

        // timestamps: arm at cycle 3, captures at cycles 5 and 9
`ifdef TRC_TIMESTAMP_EN
        ts5 = 32'd5; ts9 = 32'd9;
`else
        ts5 = 32'd0; ts9 = 32'd0;
`endif
        idle(); idle(); idle(); arm(); idle();
        wr(32'h100, 1'b0); idle(); idle(); idle(); wr(32'h104, 1'b0);
        rd(0); check("ts_first", 96'(if_a.trc_rd_ts), 96'(ts5));
        rd(1); check("ts_second", 96'(if_a.trc_rd_ts), 96'(ts9));

        // fill and wrap
        arm();
        for (int i = 0; i < 6; i++) wr(32'(4 * i), 1'b0);
        check("wrap_count", 96'(if_a.trc_count), 96'd4);
        for (int i = 0; i < 4; i++) begin
            rd(i);
            check($sformatf("wrap_pc%0d", i), 96'(if_a.trc_rd_pc), 96'(32'h08 + 4 * i));
        end
        rd(3); idle();
        check("rd_hold", 96'(if_a.trc_rd_pc), 96'h14);

        // post-trigger freeze
        arm();
        wr(32'h00, 1'b0); wr(32'h04, 1'b0); wr(32'h08, 1'b0);
        wr(32'h0C, 1'b1);
        wr(32'h10, 1'b0);
        check("post_not_done", 96'(if_a.trc_done), 96'd0);
        wr(32'h14, 1'b0);
        check("post_done", 96'(if_a.trc_done), 96'd1);
        wr(32'h18, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(i);
            check($sformatf("frz_pc%0d", i), 96'(if_a.trc_rd_pc), 96'(32'h08 + 4 * i));
        end

        // arm and trigger together from FROZEN
        step(1'b1, 1'b1, 32'h55, 32'h55, 1'b1, 1'b0, '0);
        check("armtrig_state", 96'(if_a.trc_state), 96'd1);
        check("armtrig_count", 96'(if_a.trc_count), 96'd0);
        rd(0);
        check("armtrig_rd", {if_a.trc_rd_valid, if_a.trc_rd_pc, if_a.trc_rd_inst}, {1'b1, 64'd0});

        // POST_TRIG=0 instance freezes on the trigger entry
        wr(32'h1C, 1'b0); wr(32'h20, 1'b1);
        check("pt0_state", 96'(if_b.trc_state), 96'd3);
        wr(32'h24, 1'b0);
        check("pt0_count", 96'(if_b.trc_count), 96'd2);
        rd(1);
        check("pt0_newest", 96'(if_b.trc_rd_pc), 96'h20);

        // asynchronous reset mid-POST
        arm(); wr(32'h40, 1'b1); wr(32'h44, 1'b0);
        #2 trc_rst = 1'b1;
        #1;
        check("arst_state", 96'(if_a.trc_state), 96'd0);
        check("arst_count", 96'(if_a.trc_count), 96'd0);
        check("arst_out", {if_a.trc_done, if_a.trc_rd_valid, if_a.trc_rd_pc, if_a.trc_rd_inst}, '0);
        @(negedge trc_clk);
        trc_rst = 1'b0;
        model_reset();
        wr(32'h48, 1'b0); wr(32'h4C, 1'b1); wr(32'h50, 1'b0);
        check("idle_count", 96'(if_a.trc_count), 96'd0);

        // randomized traffic
        since_arm = 0;
        for (int n = 0; n < 800; n++) begin
            logic a;
            a = ($urandom_range(0, 39) == 0) || (since_arm >= 100);
            since_arm = a ? 0 : since_arm + 1;
            step(a, $urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, DL'($urandom_range(0, DEPTH - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
